// File: rtl/knn_pkg.sv
// Shared constants and FSM encoding for the knn_vote block.
// Optional feature macro: KNN_VOTE_RANK_WEIGHT_EN (rank-weighted votes).
package knn_pkg;

    localparam int KNN_K       = 4;
    localparam int KNN_N_CLASS = 8;
    localparam int LABEL_W     = $clog2(KNN_N_CLASS);
    // One extra code point on the input so an out-of-range label can be presented and flagged.
    localparam int LABEL_IN_W  = $clog2(KNN_N_CLASS + 1);
    localparam int CNT_W       = $clog2(KNN_K * KNN_K + 1);
    localparam int RANK_W      = $clog2(KNN_K + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/knn_vote_if.sv
// Neighbour beat stream plus result/status bundle for knn_vote.
interface knn_vote_if import knn_pkg::*; ();

    logic                  nb_valid;
    logic                  nb_ready;
    logic [LABEL_IN_W-1:0] nb_label;
    logic                  nb_last;
    logic                  res_valid;
    logic                  res_ready;
    logic [LABEL_W-1:0]    res_label;
    logic [CNT_W-1:0]      res_votes;
    logic [CNT_W-1:0]      res_count;
    logic                  err;

    modport master (
        output nb_valid, nb_label, nb_last, res_ready,
        input  nb_ready, res_valid, res_label, res_votes, res_count, err
    );

    modport slave (
        input  nb_valid, nb_label, nb_last, res_ready,
        output nb_ready, res_valid, res_label, res_votes, res_count, err
    );

endinterface

// File: rtl/knn_vote_hist.sv
// Per-class vote counter bank with the rank of each class's first vote.
module knn_vote_hist import knn_pkg::*; (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic [LABEL_W-1:0] label,
    input  logic [RANK_W-1:0]  rank,
    input  logic [CNT_W-1:0]   weight,
    input  logic [LABEL_W-1:0] rd_class,
    output logic [CNT_W-1:0]   rd_votes,
    output logic [RANK_W-1:0]  rd_rank
);

    logic [CNT_W-1:0]  votes_q      [KNN_N_CLASS];
    logic [CNT_W-1:0]  votes_d      [KNN_N_CLASS];
    logic [RANK_W-1:0] first_rank_q [KNN_N_CLASS];
    logic [RANK_W-1:0] first_rank_d [KNN_N_CLASS];
    logic [CNT_W:0]    sum;

    // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        votes_d      = votes_q;
        first_rank_d = first_rank_q;
        sum          = {1'b0, votes_q[label]} + {1'b0, weight};
        if (clr) begin
            for (int c = 0; c < KNN_N_CLASS; c++) begin
                votes_d[c]      = '0;
                first_rank_d[c] = '0;
            end
        end else if (inc) begin
            votes_d[label] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            if (votes_q[label] == '0) first_rank_d[label] = rank;
        end
    end

    // NOTE: the bank is small and must read as empty after reset, so it is built from
    // resettable flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < KNN_N_CLASS; c++) begin
                votes_q[c]      <= '0;
                first_rank_q[c] <= '0;
            end
        end else begin
            votes_q      <= votes_d;
            first_rank_q <= first_rank_d;
        end
    end

    assign rd_votes = votes_q[rd_class];
    assign rd_rank  = first_rank_q[rd_class];

endmodule

// File: rtl/knn_vote.sv
// KNN majority vote: counts neighbour labels, scans the histogram, returns the winner.
// Define KNN_VOTE_RANK_WEIGHT_EN to weight a beat at rank r by K-r instead of 1.
module knn_vote import knn_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    knn_vote_if.slave   bus
);

    logic [1:0]         state_q,      state_d;
    logic [RANK_W-1:0]  rank_q,       rank_d;
    logic [LABEL_W-1:0] scan_q,       scan_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic [CNT_W-1:0]   best_votes_q, best_votes_d;
    logic [RANK_W-1:0]  best_rank_q,  best_rank_d;
    logic [LABEL_W-1:0] best_label_q, best_label_d;
    logic               res_valid_q,  res_valid_d;
    logic [LABEL_W-1:0] res_label_q,  res_label_d;
    logic [CNT_W-1:0]   res_votes_q,  res_votes_d;
    logic [CNT_W-1:0]   res_count_q,  res_count_d;
    logic               err_q,        err_d;

    logic               beat_acc, beat_ok, hist_inc, hist_clr;
    logic [CNT_W-1:0]   weight, rd_votes;
    logic [RANK_W-1:0]  rd_rank;

    assign bus.nb_ready = (state_q == IDLE) || (state_q == ACC);
    assign beat_acc     = bus.nb_valid && bus.nb_ready;
    assign beat_ok      = (bus.nb_label < LABEL_IN_W'(KNN_N_CLASS)) && (rank_q < RANK_W'(KNN_K));

`ifdef KNN_VOTE_RANK_WEIGHT_EN
    assign weight = CNT_W'(KNN_K) - CNT_W'(rank_q);
`else
    assign weight = CNT_W'(1);
`endif

    knn_vote_hist u_hist (
        .clk      (clk),
        .rst      (rst),
        .inc      (hist_inc),
        .clr      (hist_clr),
        .label    (bus.nb_label[LABEL_W-1:0]),
        .rank     (rank_q),
        .weight   (weight),
        .rd_class (scan_q),
        .rd_votes (rd_votes),
        .rd_rank  (rd_rank)
    );

    always_comb begin
        state_d      = state_q;
        rank_d       = rank_q;
        scan_d       = scan_q;
        count_d      = count_q;
        best_votes_d = best_votes_q;
        best_rank_d  = best_rank_q;
        best_label_d = best_label_q;
        res_valid_d  = res_valid_q;
        res_label_d  = res_label_q;
        res_votes_d  = res_votes_q;
        res_count_d  = res_count_q;
        err_d        = err_q;
        hist_inc     = 1'b0;
        hist_clr     = 1'b0;
        case (state_q)
            IDLE, ACC: begin
                if (beat_acc) begin
                    hist_inc = beat_ok;
                    err_d    = err_q | ~beat_ok;
                    count_d  = count_q + CNT_W'(beat_ok);
                    // Rank parks at K so every later beat in the query is rejected.
                    if (rank_q < RANK_W'(KNN_K)) rank_d = rank_q + RANK_W'(1);
                    scan_d   = '0;
                    state_d  = bus.nb_last ? SCAN : ACC;
                end
            end
            SCAN: begin
                if ((rd_votes > best_votes_q) ||
                    ((rd_votes == best_votes_q) && (rd_votes != '0) && (rd_rank < best_rank_q))) begin
                    best_votes_d = rd_votes;
                    best_rank_d  = rd_rank;
                    best_label_d = scan_q;
                end
                scan_d = scan_q + LABEL_W'(1);
                if (scan_q == LABEL_W'(KNN_N_CLASS - 1)) state_d = DONE;
            end
            default: begin
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_label_d = best_label_q;
                    res_votes_d = best_votes_q;
                    res_count_d = count_q;
                end else if (bus.res_ready) begin
                    res_valid_d  = 1'b0;
                    hist_clr     = 1'b1;
                    rank_d       = '0;
                    count_d      = '0;
                    best_votes_d = '0;
                    best_rank_d  = '1;
                    best_label_d = '0;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from
    // the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rank_q       <= '0;
            scan_q       <= '0;
            count_q      <= '0;
            best_votes_q <= '0;
            best_rank_q  <= '1;
            best_label_q <= '0;
            res_valid_q  <= 1'b0;
            res_label_q  <= '0;
            res_votes_q  <= '0;
            res_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rank_q       <= rank_d;
            scan_q       <= scan_d;
            count_q      <= count_d;
            best_votes_q <= best_votes_d;
            best_rank_q  <= best_rank_d;
            best_label_q <= best_label_d;
            res_valid_q  <= res_valid_d;
            res_label_q  <= res_label_d;
            res_votes_q  <= res_votes_d;
            res_count_q  <= res_count_d;
            err_q        <= err_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_label = res_label_q;
    assign bus.res_votes = res_votes_q;
    assign bus.res_count = res_count_q;
    assign bus.err       = err_q;

endmodule
